// File: rtl/peri_reg_arb.sv
// Two-requester round-robin bridge onto a single peripheral register bus, with a per-transaction timeout.
// Latency: cs sampled in IDLE -> reg_cs next cycle; reg_ack -> requester ack next cycle. Requesters hold cs until their own ack.
module peri_reg_arb #(
    parameter int          TO_CYC   = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        mclk,
    input  logic        s_reset,

    input  logic        m0_cs,
    input  logic        m0_wr,
    input  logic [10:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,

    input  logic        m1_cs,
    input  logic        m1_wr,
    input  logic [10:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,

    output logic        reg_cs,
    output logic        reg_wr,
    output logic [10:0] reg_addr,
    output logic [31:0] reg_wdata,
    output logic [3:0]  reg_be,
    input  logic [31:0] reg_rdata,
    input  logic        reg_ack,

    input  logic        err_clr,
    output logic        to_err,
    output logic        to_id
);

    localparam logic [7:0] TO_LIM = 8'(TO_CYC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic        ptr;
    logic        gnt_id;

    logic        win;
    logic        win_wr;
    logic [10:0] win_addr;
    logic [31:0] win_wdata;
    logic [3:0]  win_be;
    logic        busy_end;
    logic        timed_out;
    logic [31:0] done_data;

    // Single requester always wins; on contention the pointer decides.
    always_comb begin
        win = 1'b0;
        if (m0_cs && m1_cs) begin
            win = ptr;
        end else if (m1_cs) begin
            win = 1'b1;
        end
    end

    always_comb begin
        win_wr    = m0_wr;
        win_addr  = m0_addr;
        win_wdata = m0_wdata;
        win_be    = m0_be;
        if (win) begin
            win_wr    = m1_wr;
            win_addr  = m1_addr;
            win_wdata = m1_wdata;
            win_be    = m1_be;
        end
    end

    // A real ack in the timeout cycle wins over the timeout.
    always_comb begin
        timed_out = (cnt == TO_LIM) && !reg_ack;
        busy_end  = reg_ack || (cnt == TO_LIM);
        done_data = ERR_DATA;
        if (reg_ack) begin
            done_data = reg_wr ? 32'd0 : reg_rdata;
        end
    end

    always_ff @(posedge mclk) begin
        if (s_reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            ptr       <= 1'b0;
            gnt_id    <= 1'b0;
            reg_cs    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_addr  <= 11'd0;
            reg_wdata <= 32'd0;
            reg_be    <= 4'd0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= 32'd0;
            m1_rdata  <= 32'd0;
            to_err    <= 1'b0;
            to_id     <= 1'b0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            if (err_clr) begin
                to_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (m0_cs || m1_cs) begin
                        state     <= BUSY;
                        gnt_id    <= win;
                        ptr       <= ~win;
                        cnt       <= 8'd1;
                        reg_cs    <= 1'b1;
                        reg_wr    <= win_wr;
                        reg_addr  <= win_addr;
                        reg_wdata <= win_wdata;
                        reg_be    <= win_be;
                    end
                end
                BUSY: begin
                    if (busy_end) begin
                        state  <= DONE;
                        reg_cs <= 1'b0;
                        if (gnt_id) begin
                            m1_ack   <= 1'b1;
                            m1_rdata <= done_data;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_rdata <= done_data;
                        end
                        if (timed_out) begin
                            to_err <= 1'b1;
                            to_id  <= gnt_id;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
                default: begin
                    state  <= IDLE;
                    reg_cs <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peri_reg_arb.sv
// Directed and randomized transactions on peri_reg_arb checked against a transaction-level model.
module tb_peri_reg_arb;

    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        mclk = 1'b0;
    logic        s_reset;
    logic        m0_cs, m0_wr, m1_cs, m1_wr;
    logic [10:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic        reg_cs, reg_wr;
    logic [10:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic        err_clr;
    logic        to_err, to_id;

    int checks = 0;
    int failures = 0;

    // Pending requests per requester and the expected observable state.
    logic        p_vld[2];
    logic        p_wr[2];
    logic [10:0] p_addr[2];
    logic [31:0] p_wdata[2];
    logic [3:0]  p_be[2];
    int          ptr_m;
    logic [31:0] rd_m[2];
    logic        to_err_m;
    logic        to_id_m;

    peri_reg_arb #(.TO_CYC(TO), .ERR_DATA(ERR)) dut (
        .mclk(mclk), .s_reset(s_reset),
        .m0_cs(m0_cs), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_cs(m1_cs), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_be(reg_be),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack),
        .err_clr(err_clr), .to_err(to_err), .to_id(to_id)
    );

    initial forever #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic drive();
        m0_cs = p_vld[0]; m0_wr = p_wr[0]; m0_addr = p_addr[0]; m0_wdata = p_wdata[0]; m0_be = p_be[0];
        m1_cs = p_vld[1]; m1_wr = p_wr[1]; m1_addr = p_addr[1]; m1_wdata = p_wdata[1]; m1_be = p_be[1];
    endtask

    task automatic set_req(input int id, input logic wr, input logic [10:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        p_vld[id] = 1'b1; p_wr[id] = wr; p_addr[id] = addr; p_wdata[id] = wdata; p_be[id] = be;
    endtask

    task automatic model_reset();
        ptr_m = 0; rd_m[0] = 32'd0; rd_m[1] = 32'd0; to_err_m = 1'b0; to_id_m = 1'b0;
        p_vld[0] = 1'b0; p_vld[1] = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_reg_cs"}, 32'(reg_cs), 32'd0);
        chk({tag, "_reg_wr"}, 32'(reg_wr), 32'd0);
        chk({tag, "_reg_addr"}, 32'(reg_addr), 32'd0);
        chk({tag, "_reg_wdata"}, reg_wdata, 32'd0);
        chk({tag, "_reg_be"}, 32'(reg_be), 32'd0);
        chk({tag, "_acks"}, 32'({m1_ack, m0_ack}), 32'd0);
        chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
        chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
        chk({tag, "_to_err"}, 32'(to_err), 32'd0);
        chk({tag, "_to_id"}, 32'(to_id), 32'd0);
    endtask

    // One grant from an IDLE observation point back to the next IDLE observation point.
    // dly: counter value at which the peripheral acks; dly > TO means it never does.
    task automatic round(input int dly, input logic [31:0] rd, input bit clr_to, input bit drop);
        int w;
        int last;
        bit timeout;
        logic [31:0] exp_d;
        if (p_vld[0] && p_vld[1]) w = ptr_m;
        else if (p_vld[1]) w = 1;
        else w = 0;
        ptr_m = 1 - w;
        if (err_clr) to_err_m = 1'b0;
        last = (dly < TO) ? dly : TO;
        timeout = (dly > TO);
        drive();
        tick();
        for (int k = 1; k <= last; k++) begin
            chk("busy_reg_cs", 32'(reg_cs), 32'd1);
            chk("busy_reg_wr", 32'(reg_wr), 32'(p_wr[w]));
            chk("busy_reg_addr", 32'(reg_addr), 32'(p_addr[w]));
            chk("busy_reg_wdata", reg_wdata, p_wdata[w]);
            chk("busy_reg_be", 32'(reg_be), 32'(p_be[w]));
            chk("busy_acks", 32'({m1_ack, m0_ack}), 32'd0);
            if (drop && k == 1) begin
                p_vld[w] = 1'b0;
                drive();
            end
            reg_ack   = (k == dly);
            reg_rdata = (k == dly) ? rd : $urandom;
            err_clr   = clr_to && (k == TO);
            tick();
        end
        if (err_clr) to_err_m = 1'b0;
        reg_ack = 1'b0;
        err_clr = 1'b0;
        exp_d = timeout ? ERR : (p_wr[w] ? 32'd0 : rd);
        rd_m[w] = exp_d;
        if (timeout) begin
            to_err_m = 1'b1;
            to_id_m  = w[0];
        end
        chk("done_acks", 32'({m1_ack, m0_ack}), (w == 1) ? 32'd2 : 32'd1);
        chk("done_m0_rdata", m0_rdata, rd_m[0]);
        chk("done_m1_rdata", m1_rdata, rd_m[1]);
        chk("done_reg_cs", 32'(reg_cs), 32'd0);
        chk("done_to_err", 32'(to_err), 32'(to_err_m));
        chk("done_to_id", 32'(to_id), 32'(to_id_m));
        p_vld[w] = 1'b0;
        drive();
        reg_ack   = 1'($urandom_range(0, 1));
        reg_rdata = $urandom;
        tick();
        chk("idle_acks", 32'({m1_ack, m0_ack}), 32'd0);
        chk("idle_reg_cs", 32'(reg_cs), 32'd0);
        chk("idle_m0_rdata", m0_rdata, rd_m[0]);
        chk("idle_m1_rdata", m1_rdata, rd_m[1]);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        to_err_m = 1'b0;
        chk("err_clr_to_err", 32'(to_err), 32'd0);
    endtask

    initial begin
        s_reset = 1'b1; reg_ack = 1'b0; reg_rdata = 32'd0; err_clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            p_wr[i] = 1'b0; p_addr[i] = 11'd0; p_wdata[i] = 32'd0; p_be[i] = 4'd0;
        end
        model_reset();
        drive();
        repeat (3) tick();
        chk_reset_outputs("reset");
        s_reset = 1'b0;
        tick();

        // Simultaneous requests after reset: m0, m1, then again m0, m1.
        set_req(0, 1'b0, 11'h010, 32'h0, 4'hF);
        set_req(1, 1'b0, 11'h020, 32'h0, 4'hF);
        round(2, 32'h1111_0000, 1'b0, 1'b0);
        round(3, 32'h2222_0000, 1'b0, 1'b0);
        set_req(0, 1'b0, 11'h030, 32'h0, 4'hF);
        set_req(1, 1'b0, 11'h040, 32'h0, 4'hF);
        round(1, 32'h3333_0000, 1'b0, 1'b0);
        round(4, 32'h4444_0000, 1'b0, 1'b0);

        // Plain m0 read.
        set_req(0, 1'b0, 11'h085, 32'h0, 4'hF);
        round(3, 32'h1234_5678, 1'b0, 1'b0);

        // m1 write, reg_* held for the whole busy period.
        set_req(1, 1'b1, 11'h100, 32'hA5A5_A5A5, 4'hF);
        round(5, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Timeout on m0, then clear.
        set_req(0, 1'b0, 11'h055, 32'h0, 4'h3);
        round(TO + 3, 32'h0, 1'b0, 1'b0);
        chk("to_err_set", 32'(to_err), 32'd1);
        chk("to_id_m0", 32'(to_id), 32'd0);
        reg_ack = 1'b0;
        clear_err();

        // Ack exactly at the timeout count is a normal completion.
        set_req(1, 1'b0, 11'h077, 32'h0, 4'hF);
        round(TO, 32'hCAFE_F00D, 1'b0, 1'b0);
        chk("coincident_no_err", 32'(to_err), 32'd0);

        // Timeout in the same cycle as err_clr leaves the flag set.
        set_req(1, 1'b0, 11'h078, 32'h0, 4'hF);
        round(TO + 1, 32'h0, 1'b1, 1'b0);
        chk("to_err_vs_clr", 32'(to_err), 32'd1);
        chk("to_id_m1", 32'(to_id), 32'd1);

        // Reset in the middle of a busy period.
        reg_ack = 1'b0;
        set_req(0, 1'b1, 11'h3FF, 32'h5555_AAAA, 4'h9);
        drive();
        repeat (3) tick();
        chk("pre_reset_reg_cs", 32'(reg_cs), 32'd1);
        s_reset = 1'b1;
        tick();
        chk_reset_outputs("mid_busy_reset");
        s_reset = 1'b0;
        model_reset();
        drive();
        repeat (TO + 2) begin
            tick();
            chk("abandoned_no_ack", 32'({m1_ack, m0_ack}), 32'd0);
        end
        set_req(0, 1'b0, 11'h001, 32'h0, 4'hF);
        set_req(1, 1'b0, 11'h002, 32'h0, 4'hF);
        round(2, 32'h0BAD_F00D, 1'b0, 1'b0);
        round(2, 32'h600D_F00D, 1'b0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            for (int id = 0; id < 2; id++) begin
                if (!p_vld[id] && $urandom_range(0, 1) == 1)
                    set_req(id, 1'($urandom_range(0, 1)), 11'($urandom), $urandom, 4'($urandom));
            end
            if (!p_vld[0] && !p_vld[1])
                set_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 11'($urandom), $urandom, 4'($urandom));
            err_clr = ($urandom_range(0, 7) == 0);
            round(int'($urandom_range(1, TO + 2)), $urandom,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/peri_reg_arb.md
PERI_REG_ARB -- requirements
Module: peri_reg_arb

Interface
REQ-001 Parameter: TO_CYC, default 255, max BUSY cycles before timeout, range 2..255.
REQ-002 Parameter: ERR_DATA, default 32'hDEAD_BEEF, read data returned on timeout.
REQ-003 Port: mclk  in  1  sole clock; all logic on rising edge.
REQ-004 Port: s_reset  in  1  reset, synchronous and active-high.
REQ-005 Port: m0_cs, m1_cs  in  1 each  requester select; held until own ack.
REQ-006 Port: m0_wr, m1_wr  in  1 each  1=write, 0=read.
REQ-007 Port: m0_addr, m1_addr  in  11 each  register address.
REQ-008 Port: m0_wdata, m1_wdata  in  32 each  write data.
REQ-009 Port: m0_be, m1_be  in  4 each  byte enables.
REQ-010 Port: m0_rdata, m1_rdata  out  32 each  read data, valid with ack.
REQ-011 Port: m0_ack, m1_ack  out  1 each  one-cycle completion pulse.
REQ-012 Port: reg_cs, reg_wr, reg_addr[10:0], reg_wdata[31:0], reg_be[3:0]  out  peripheral bus request.
REQ-013 Port: reg_rdata  in  32  peripheral read data.
REQ-014 Port: reg_ack  in  1  peripheral completion.
REQ-015 Port: err_clr  in  1  clears timeout status.
REQ-016 Port: to_err  out  1  sticky timeout flag.
REQ-017 Port: to_id  out  1  requester of last timeout (0=m0, 1=m1).

Function
REQ-018 FSM states IDLE, BUSY, DONE; all bus outputs registered.
REQ-019 IDLE: no cs -> stay IDLE; any cs -> latch winner wr/addr/wdata/be, set reg_cs=1 next cycle, enter BUSY.
REQ-020 Arbitration round-robin: single requester wins; both request -> priority pointer wins.
REQ-021 Pointer points to the non-granted requester after every grant; pointer = m0 after reset.
REQ-022 BUSY: reg_* outputs stable at latched values; 8-bit cycle counter increments each cycle from 1.
REQ-023 BUSY with reg_ack=1 -> capture reg_rdata (reads; writes capture 0), reg_cs=0 next cycle, enter DONE.
REQ-024 BUSY with counter=TO_CYC and reg_ack=0 -> capture ERR_DATA, reg_cs=0, to_err=1, to_id=granted id, enter DONE.
REQ-025 reg_ack and timeout in the same cycle -> treated as normal ack, no error.
REQ-026 DONE: granted mN_ack=1 for exactly one cycle with mN_rdata=captured data; other ack 0; next state IDLE.
REQ-027 Latency: cs sampled in IDLE cycle N -> reg_cs high N+1; reg_ack at cycle K -> mN_ack at K+1.
REQ-028 Minimum one cycle with reg_cs=0 between consecutive peripheral transactions (DONE cycle).
REQ-029 mN_rdata holds last captured value between acks; never driven to the non-granted requester.
REQ-030 Requester dropping cs in BUSY does not abort; transaction completes; ack still pulsed.
REQ-031 reg_ack in IDLE or DONE ignored.
REQ-032 err_clr=1 clears to_err next cycle; new timeout same cycle as err_clr -> to_err stays 1.

Reset
REQ-033 s_reset=1 at any edge -> state IDLE, reg_cs=0, reg_wr=0, reg_addr=0, reg_wdata=0, reg_be=0, m0/m1_ack=0, m0/m1_rdata=0, counter=0, pointer=m0, to_err=0, to_id=0.
REQ-034 Reset mid-BUSY abandons transaction; no ack is issued for it.

Verification
REQ-035 m0 read addr 0x085, reg_ack 3 cycles after reg_cs, reg_rdata 0x1234_5678 -> m0_ack one pulse, m0_rdata 0x1234_5678, m1_ack 0.
REQ-036 m0 and m1 cs same cycle after reset -> m0 granted first, m1 granted after DONE; repeat -> order m0, m1, m0, m1.
REQ-037 m1 write addr 0x100 wdata 0xA5A5_A5A5 be 0xF -> reg_* match exactly for whole BUSY; m1_ack after reg_ack.
REQ-038 TO_CYC=8, no reg_ack -> m0_ack at counter 8 plus 1 cycle, m0_rdata 0xDEAD_BEEF, to_err=1, to_id=0; err_clr -> to_err=0.
REQ-039 reg_ack coincident with counter=TO_CYC -> real data returned, to_err stays 0.
REQ-040 s_reset asserted mid-BUSY -> all outputs reset values next cycle, no ack; fresh request then completes normally.
